// File: rtl/memory_pkg.sv
// ------------------------------------------------------------------
// memory_pkg : shared types and sizing helpers for memory_ws
// Revision   : 1.0
// ------------------------------------------------------------------
`default_nettype none

package memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTE_LANES         = DEFAULT_DATA_WIDTH / 8;
  localparam int OFFSET_BITS        = $clog2(BYTE_LANES);
  localparam int CNT_W              = 4;

  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

  // A byte-wide memory has no offset field at all.
  function automatic int offset_of(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_ws_array.sv
// ------------------------------------------------------------------
// memory_ws_array : word storage, per-lane write, registered read
// Revision        : 1.0
// ------------------------------------------------------------------
`default_nettype none

module memory_ws_array
    import memory_pkg::*;
#(
    parameter string MEMORY_FILE = "",
    parameter int    DEPTH       = 4096,
    parameter int    DATA_WIDTH  = 32,
    parameter int    ADDR_W      = 12
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    input  logic [ADDR_W-1:0]       raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int LANES = lanes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < LANES; k++) begin
                if (be_i[k]) mem[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/memory_ws.sv
// ------------------------------------------------------------------
// memory_ws : word RAM with byte strobes, wait states and error ack
// Revision  : 1.0
// ------------------------------------------------------------------
`default_nettype none

module memory_ws
  import memory_pkg::*;
#(
  parameter string MEMORY_FILE = "",
  parameter int    MEMORY_SIZE = 4096,
  parameter int    DATA_WIDTH  = 32,
  parameter int    WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    rd_en_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int LANES = lanes_of(DATA_WIDTH);
  localparam int OFFS  = offset_of(DATA_WIDTH);
  localparam int AW    = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]      be_q, be_d;

  logic [31-OFFS:0]      w_idx;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_err_in;
  logic                  w_enter_resp;
  logic                  w_in_idle;
  logic                  w_is_write;
  logic                  w_mem_we;
  logic [AW-1:0]         w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [LANES-1:0]      w_mem_be;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_idx = addr_i[31:OFFS];

  generate
    if (OFFS > 0) begin : g_offset_chk
      assign w_misaligned = |addr_i[OFFS-1:0];
    end else begin : g_no_offset
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_out_of_range = (32'(w_idx) >= 32'(MEMORY_SIZE));
  assign w_err_in       = w_misaligned | w_out_of_range | (rd_en_i & wr_en_i);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    data_d  = data_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (rd_en_i | wr_en_i) begin
          wr_d   = wr_en_i;
          err_d  = w_err_in;
          idx_d  = w_idx[AW-1:0];
          data_d = data_i;
          be_d   = be_i;
          // Rejected accesses skip the wait states entirely.
          if (w_err_in || WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the array is touched on the accepting edge itself,
  // so address/data come straight from the bus while idle.
  assign w_in_idle    = (state_q == IDLE);
  assign w_enter_resp = (state_d == RESP) && (state_q != RESP) && !rst_i;
  assign w_is_write   = w_in_idle ? (wr_en_i & ~w_err_in) : (wr_q & ~err_q);
  assign w_mem_we     = w_enter_resp & w_is_write;
  assign w_mem_addr   = w_in_idle ? w_idx[AW-1:0] : idx_q;
  assign w_mem_wdata  = w_in_idle ? data_i : data_q;
  assign w_mem_be     = w_in_idle ? be_i : be_q;

  memory_ws_array #(
    .MEMORY_FILE (MEMORY_FILE),
    .DEPTH       (MEMORY_SIZE),
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_W      (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (w_mem_we),
    .be_i    (w_mem_be),
    .waddr_i (w_mem_addr),
    .wdata_i (w_mem_wdata),
    .re_i    (w_enter_resp),
    .raddr_i (w_mem_addr),
    .rdata_o (w_mem_rdata)
  );

  assign ack_o  = (state_q == RESP);
  assign err_o  = ack_o & err_q;
  assign busy_o = (state_q != IDLE);
  assign data_o = (ack_o && !wr_q && !err_q) ? w_mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_memory_ws.sv
// ------------------------------------------------------------------
// tb_memory_ws : directed checks on three memory_ws configurations
// Revision     : 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_memory_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [3:0]  be   [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];
  logic        busy [3];

  int checks   = 0;
  int failures = 0;

  memory_ws #(.MEMORY_FILE(""), .MEMORY_SIZE(64), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_i(rst[0]), .rd_en_i(rd[0]), .wr_en_i(wr[0]), .be_i(be[0]),
    .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]), .ack_o(ack[0]),
    .err_o(err[0]), .busy_o(busy[0]));

  memory_ws #(.MEMORY_FILE(""), .MEMORY_SIZE(64), .DATA_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_i(rst[1]), .rd_en_i(rd[1]), .wr_en_i(wr[1]), .be_i(be[1]),
    .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]), .ack_o(ack[1]),
    .err_o(err[1]), .busy_o(busy[1]));

  memory_ws #(.MEMORY_FILE(""), .MEMORY_SIZE(64), .DATA_WIDTH(32), .WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rst_i(rst[2]), .rd_en_i(rd[2]), .wr_en_i(wr[2]), .be_i(be[2]),
    .addr_i(addr[2]), .data_i(wdat[2]), .data_o(rdat[2]), .ack_o(ack[2]),
    .err_o(err[2]), .busy_o(busy[2]));

  // Bus master: hold the request until ack is seen, drop it just after the next edge.
  task automatic xact(input int u, input logic r, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] q, output logic e, output int lat);
    @(negedge clk);
    rd[u] = r; wr[u] = w; be[u] = b; addr[u] = a; wdat[u] = d;
    @(posedge clk);
    lat = -1; q = '0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack[u]) begin
        lat = i; q = rdat[u]; e = err[u];
        break;
      end
    end
    @(posedge clk);
    #1;
    rd[u] = 1'b0; wr[u] = 1'b0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0; be[u] = '0; addr[u] = '0; wdat[u] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks += 4;
      if (ack[u] !== 1'b0) begin failures++; $display("FAIL reset_ack u%0d got=%b exp=0", u, ack[u]); end
      if (err[u] !== 1'b0) begin failures++; $display("FAIL reset_err u%0d got=%b exp=0", u, err[u]); end
      if (busy[u] !== 1'b0) begin failures++; $display("FAIL reset_busy u%0d got=%b exp=0", u, busy[u]); end
      if (rdat[u] !== 32'h0) begin failures++; $display("FAIL reset_data u%0d got=%h exp=0", u, rdat[u]); end
    end
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] q; logic e; int lat;
    xact(0, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, q, e, lat);
    checks += 3;
    if (lat !== 1) begin failures++; $display("FAIL wr_latency got=%0d exp=1", lat); end
    if (e !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", e); end
    if (q !== 32'h0) begin failures++; $display("FAIL wr_data_o got=%h exp=0", q); end
    xact(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, q, e, lat);
    checks += 3;
    if (lat !== 1) begin failures++; $display("FAIL rd_latency got=%0d exp=1", lat); end
    if (e !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", e); end
    if (q !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", q); end
    // Held enable across the RESP->IDLE edge must not start a second access.
    @(negedge clk);
    checks += 2;
    if (ack[0] !== 1'b0) begin failures++; $display("FAIL no_retrigger_ack got=%b exp=0", ack[0]); end
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL no_retrigger_busy got=%b exp=0", busy[0]); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] q; logic e; int lat;
    xact(0, 1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, q, e, lat);
    xact(0, 1'b0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, q, e, lat);
    xact(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, q, e, lat);
    checks++;
    if (q !== 32'h11BB33DD) begin failures++; $display("FAIL lanes_0101 got=%h exp=11bb33dd", q); end
    xact(0, 1'b0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, q, e, lat);
    checks += 2;
    if (lat !== 1) begin failures++; $display("FAIL be0_ack_latency got=%0d exp=1", lat); end
    if (e !== 1'b0) begin failures++; $display("FAIL be0_err got=%b exp=0", e); end
    xact(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, q, e, lat);
    checks++;
    if (q !== 32'h11BB33DD) begin failures++; $display("FAIL be0_noop got=%h exp=11bb33dd", q); end
  endtask

  task automatic test_wait_states();
    logic [31:0] q; logic e; int lat;
    int busyc, acks, ack_at;
    xact(1, 1'b0, 1'b1, 4'hF, 32'h8, 32'h55AA00FF, q, e, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ws3_wr_latency got=%0d exp=4", lat); end
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 32'h8;
    @(posedge clk);
    busyc = 0; acks = 0; ack_at = 0; q = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy[1]) busyc++;
      if (ack[1]) begin acks++; ack_at = i; q = rdat[1]; end
      if (i == 1) rd[1] = 1'b0;
      if (i == 2) rd[1] = 1'b1;
      if (i == 3) rd[1] = 1'b0;
    end
    checks += 4;
    if (busyc != 4) begin failures++; $display("FAIL ws3_busy_cycles got=%0d exp=4", busyc); end
    if (acks != 1) begin failures++; $display("FAIL ws3_ack_count got=%0d exp=1", acks); end
    if (ack_at != 4) begin failures++; $display("FAIL ws3_rd_latency got=%0d exp=4", ack_at); end
    if (q !== 32'h55AA00FF) begin failures++; $display("FAIL ws3_rd_data got=%h exp=55aa00ff", q); end
  endtask

  task automatic test_errors();
    logic [31:0] q; logic e; int lat;
    xact(0, 1'b1, 1'b0, 4'h0, 32'h12, 32'h0, q, e, lat);
    checks += 3;
    if (lat !== 1) begin failures++; $display("FAIL misalign_latency got=%0d exp=1", lat); end
    if (e !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", e); end
    if (q !== 32'h0) begin failures++; $display("FAIL misalign_data got=%h exp=0", q); end
    xact(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, q, e, lat);
    checks += 2;
    if (e !== 1'b1) begin failures++; $display("FAIL range_err got=%b exp=1", e); end
    if (q !== 32'h0) begin failures++; $display("FAIL range_data got=%h exp=0", q); end
    xact(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h0, q, e, lat);
    checks += 2;
    if (e !== 1'b1) begin failures++; $display("FAIL rdwr_err got=%b exp=1", e); end
    if (q !== 32'h0) begin failures++; $display("FAIL rdwr_data got=%h exp=0", q); end
    xact(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, q, e, lat);
    checks++;
    if (q !== 32'hDEADBEEF) begin failures++; $display("FAIL err_mem_unchanged got=%h exp=deadbeef", q); end
    xact(1, 1'b1, 1'b0, 4'h0, 32'h12, 32'h0, q, e, lat);
    checks += 2;
    if (lat !== 1) begin failures++; $display("FAIL ws3_err_latency got=%0d exp=1", lat); end
    if (e !== 1'b1) begin failures++; $display("FAIL ws3_err got=%b exp=1", e); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] q; logic e; int lat;
    int acks;
    xact(2, 1'b0, 1'b1, 4'hF, 32'h40, 32'h12345678, q, e, lat);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL ws5_wr_latency got=%0d exp=6", lat); end
    @(negedge clk);
    wr[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h40; wdat[2] = 32'hCAFE0000;
    @(posedge clk);
    @(negedge clk);
    wr[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[2] !== 1'b1) begin failures++; $display("FAIL ws5_busy_in_wait got=%b exp=1", busy[2]); end
    rst[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b0;
    checks++;
    if (busy[2] !== 1'b0) begin failures++; $display("FAIL ws5_busy_after_rst got=%b exp=0", busy[2]); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack[2]) acks++;
    end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL ws5_abort_ack got=%0d exp=0", acks); end
    xact(2, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, q, e, lat);
    checks += 2;
    if (lat !== 6) begin failures++; $display("FAIL ws5_rd_latency got=%0d exp=6", lat); end
    if (q !== 32'h12345678) begin failures++; $display("FAIL ws5_old_value got=%h exp=12345678", q); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
